// File: rtl/text_pkg.sv
// Shared definitions for the typewriter text path: ASCII control codes,
// the writer FSM states and the key classes produced by text_key_class.
package text_pkg;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TILDE = 8'h7E;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    CLEAR
  } state_e;

  typedef enum logic [2:0] {
    KEY_PRINT,
    KEY_BS,
    KEY_NEWLINE,
    KEY_CLEAR,
    KEY_OTHER
  } key_class_e;

endpackage

// File: rtl/text_cursor_writer_if.sv
// Key handshake plus RAM write side of the text cursor writer.
// master = key source / RAM side, slave = the writer block.
interface text_cursor_writer_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);

  logic              key_valid;
  logic [DATA_W-1:0] key_data;
  logic              key_ready;
  logic              we;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] d;
  logic [ADDR_W-1:0] cursor;
  logic              busy;

  modport master (
    output key_valid, key_data,
    input  key_ready, we, write_address, d, cursor, busy
  );

  modport slave (
    input  key_valid, key_data,
    output key_ready, we, write_address, d, cursor, busy
  );

endinterface

// File: rtl/text_key_class.sv
// Combinational ASCII key classifier; shared by the writer and any later
// echo/logging stage. ESC is always reported as KEY_CLEAR; whether it does
// anything is up to the consumer.
module text_key_class
  import text_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] key_data_i,
  output key_class_e        key_class_o
);

  // Map the raw key code onto one of the five classes.
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    key_class_o = KEY_OTHER;
    if (key_data_i >= DATA_W'(ASCII_SPACE) && key_data_i <= DATA_W'(ASCII_TILDE)) begin
      key_class_o = KEY_PRINT;
    end else if (key_data_i == DATA_W'(ASCII_BS)) begin
      key_class_o = KEY_BS;
    end else if (key_data_i == DATA_W'(ASCII_CR) || key_data_i == DATA_W'(ASCII_LF)) begin
      key_class_o = KEY_NEWLINE;
    end else if (key_data_i == DATA_W'(ASCII_ESC)) begin
      key_class_o = KEY_CLEAR;
    end
  end

endmodule

// File: rtl/text_cursor_writer.sv
// Text cursor writer: turns accepted key codes into single-cycle writes to
// the character RAM and tracks the cursor for the display overlay.
// Optional feature: define TEXT_CURSOR_WRITER_CLEAR_EN to make ESC sweep the
// whole buffer with spaces (CLEAR state); undefined, ESC is ignored and busy
// is tied low.
module text_cursor_writer
  import text_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int COLS   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  text_cursor_writer_if.slave   bus
);

  localparam logic [ADDR_W-1:0] COL_MASK = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);

  state_e            state_q;
  logic [ADDR_W-1:0] cursor_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              we_q;

  key_class_e        key_class;
  logic              accept;
  logic [ADDR_W-1:0] cursor_nl_d;

  text_key_class #(.DATA_W(DATA_W)) u_key_class (
    .key_data_i  (bus.key_data),
    .key_class_o (key_class)
  );

  assign accept = bus.key_valid && (state_q == IDLE);

  // Start of the next row; a COLS-wide step past the last row wraps to 0.
  always_comb begin
    cursor_nl_d = (cursor_q & ~COL_MASK) + ROW_STEP;
  end

  // FSM with registered write outputs and cursor.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: every register here, including the write port outputs, takes a
    // known value on reset; the RAM itself is outside and is never reset.
    if (reset) begin
      state_q  <= IDLE;
      cursor_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the
      // same pre-edge values.
      unique case (state_q)
        IDLE: begin
          we_q <= 1'b0;
          if (accept) begin
            unique case (key_class)
              KEY_PRINT: begin
                state_q  <= EMIT;
                we_q     <= 1'b1;
                addr_q   <= cursor_q;
                data_q   <= bus.key_data;
                cursor_q <= cursor_q + ADDR_W'(1);
              end
              KEY_BS: begin
                // Backspace at the origin is swallowed without a write.
                if (cursor_q != '0) begin
                  state_q  <= EMIT;
                  we_q     <= 1'b1;
                  addr_q   <= cursor_q - ADDR_W'(1);
                  data_q   <= DATA_W'(ASCII_SPACE);
                  cursor_q <= cursor_q - ADDR_W'(1);
                end
              end
              KEY_NEWLINE: begin
                cursor_q <= cursor_nl_d;
              end
`ifdef TEXT_CURSOR_WRITER_CLEAR_EN
              KEY_CLEAR: begin
                // The write address doubles as the sweep counter.
                state_q  <= CLEAR;
                we_q     <= 1'b1;
                addr_q   <= '0;
                data_q   <= DATA_W'(ASCII_SPACE);
                cursor_q <= '0;
              end
`endif
              default: begin
              end
            endcase
          end
        end
        EMIT: begin
          state_q <= IDLE;
          we_q    <= 1'b0;
        end
`ifdef TEXT_CURSOR_WRITER_CLEAR_EN
        CLEAR: begin
          if (addr_q == '1) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
          end else begin
            addr_q  <= addr_q + ADDR_W'(1);
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.key_ready     = (state_q == IDLE);
  assign bus.we            = we_q;
  assign bus.write_address = addr_q;
  assign bus.d             = data_q;
  assign bus.cursor        = cursor_q;
`ifdef TEXT_CURSOR_WRITER_CLEAR_EN
  assign bus.busy          = (state_q == CLEAR);
`else
  assign bus.busy          = 1'b0;
`endif

endmodule

// File: tb/tb_text_cursor_writer.sv
// Self-checking bench for text_cursor_writer: directed cases plus random key
// streams compared against a cursor/RAM model, with a shadow RAM built from
// the write port and compared at the end.
module tb_text_cursor_writer;
  import text_pkg::*;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int COLS   = 16;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef TEXT_CURSOR_WRITER_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  text_cursor_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  text_cursor_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .COLS(COLS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state.
  logic [7:0] model_ram [DEPTH];
  int         cur;

  // RAM as seen through the write port.
  logic [7:0] shadow [DEPTH];
  logic       init_shadow;

  always @(posedge clk) begin
    if (init_shadow) begin
      for (int i = 0; i < DEPTH; i++) shadow[i] <= 8'h00;
    end else if (bus.we) begin
      shadow[bus.write_address] <= bus.d;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural effect of one accepted key.
  task automatic model_key(input logic [7:0] k, output bit wr, output int waddr,
                           output logic [7:0] wdata, output bit clr);
    wr = 1'b0; waddr = 0; wdata = 8'h00; clr = 1'b0;
    if (k >= 8'h20 && k <= 8'h7E) begin
      wr = 1'b1; waddr = cur; wdata = k;
      model_ram[cur] = k;
      cur = (cur + 1) % DEPTH;
    end else if (k == 8'h08) begin
      if (cur != 0) begin
        cur = cur - 1;
        wr = 1'b1; waddr = cur; wdata = 8'h20;
        model_ram[cur] = 8'h20;
      end
    end else if (k == 8'h0D || k == 8'h0A) begin
      cur = (((cur / COLS) + 1) * COLS) % DEPTH;
    end else if (k == 8'h1B && CLEAR_EN) begin
      clr = 1'b1;
      cur = 0;
    end
  endtask

  // Checks the 64-cycle clear sweep; entered #1 after the accepting edge.
  task automatic check_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      check("sweep", 32'({bus.we, bus.busy, bus.key_ready, bus.write_address, bus.d}),
            32'({1'b1, 1'b1, 1'b0, 6'(i), 8'h20}));
      model_ram[i] = 8'h20;
      @(posedge clk); #1;
    end
    check("sweep_end", 32'({bus.we, bus.busy, bus.key_ready}), 32'(3'b001));
    check("sweep_cursor", 32'(bus.cursor), 32'(cur));
  endtask

  task automatic send_key(input logic [7:0] k);
    bit wr, clr;
    int waddr, n;
    logic [7:0] wdata;
    @(negedge clk);
    n = 0;
    while (!bus.key_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.key_ready) begin
      check("ready_timeout", 32'(bus.key_ready), 32'(1));
      return;
    end
    bus.key_valid = 1'b1;
    bus.key_data  = k;
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    bus.key_data  = 8'($urandom);
    model_key(k, wr, waddr, wdata, clr);
    if (clr) begin
      check_sweep();
    end else begin
      check("cursor", 32'(bus.cursor), 32'(cur));
      check("we", 32'(bus.we), 32'(wr));
      check("busy", 32'(bus.busy), 32'(0));
      if (wr) begin
        check("addr", 32'(bus.write_address), 32'(waddr));
        check("data", 32'(bus.d), 32'(wdata));
        check("ready_emit", 32'(bus.key_ready), 32'(0));
        @(posedge clk); #1;
        check("we_pulse", 32'(bus.we), 32'(0));
        check("ready_after", 32'(bus.key_ready), 32'(1));
      end else begin
        check("ready_kept", 32'(bus.key_ready), 32'(1));
      end
    end
  endtask

  task automatic send_printables(input int count);
    for (int i = 0; i < count; i++) send_key(8'($urandom_range(32, 126)));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit         wr, clr;
    int         waddr;
    logic [7:0] wdata;
    int         r;

    reset         = 1'b1;
    init_shadow   = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_data  = 8'h00;
    cur           = 0;
    for (int i = 0; i < DEPTH; i++) model_ram[i] = 8'h00;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 32'(bus.we), 32'(0));
    check("rst_addr", 32'(bus.write_address), 32'(0));
    check("rst_d", 32'(bus.d), 32'(0));
    check("rst_cursor", 32'(bus.cursor), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_ready", 32'(bus.key_ready), 32'(1));
    @(negedge clk);
    reset       = 1'b0;
    init_shadow = 1'b0;

    // 'A', 'B' at addresses 0 and 1.
    send_key(8'h41);
    send_key(8'h42);
    check("ab_cursor", 32'(bus.cursor), 32'(2));

    // Four newlines bring the cursor back to 0, then 65 printables wrap it.
    repeat (4) send_key(8'h0D);
    check("nl_wrap0", 32'(bus.cursor), 32'(0));
    send_printables(64);
    check("wrap64_cursor", 32'(bus.cursor), 32'(0));
    send_printables(1);
    check("wrap65_cursor", 32'(bus.cursor), 32'(1));

    // Backspace at 5, then at 0.
    send_printables(4);
    send_key(8'h08);
    check("bs5_cursor", 32'(bus.cursor), 32'(4));
    repeat (4) send_key(8'h0A);
    send_key(8'h08);
    check("bs0_cursor", 32'(bus.cursor), 32'(0));

    // CR from 17 -> 32; LF from 50 -> 0.
    send_key(8'h0D);
    send_printables(1);
    send_key(8'h0D);
    check("cr17_cursor", 32'(bus.cursor), 32'(32));
    send_key(8'h0D);
    send_printables(2);
    send_key(8'h0A);
    check("lf50_cursor", 32'(bus.cursor), 32'(0));

    // ESC from cursor 9: sweep when enabled, ignored otherwise.
    send_printables(9);
    send_key(8'h1B);

`ifdef TEXT_CURSOR_WRITER_CLEAR_EN
    // Key held valid through a sweep is only taken once the sweep ends.
    send_printables(3);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_data  = 8'h1B;
    @(posedge clk); #1;
    bus.key_data  = 8'h5A;
    model_key(8'h1B, wr, waddr, wdata, clr);
    check_sweep();
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    model_key(8'h5A, wr, waddr, wdata, clr);
    check("held_we", 32'(bus.we), 32'(wr));
    check("held_addr", 32'(bus.write_address), 32'(waddr));
    check("held_data", 32'(bus.d), 32'(wdata));
    check("held_cursor", 32'(bus.cursor), 32'(cur));
    @(posedge clk); #1;
    check("held_we_pulse", 32'(bus.we), 32'(0));
`endif

    // Random key stream.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      send_key(8'($urandom_range(32, 126)));
      else if (r < 70) send_key(8'h08);
      else if (r < 80) send_key(($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A);
      else if (r < 88) send_key(8'($urandom_range(127, 255)));
      else if (r < 92) send_key(8'($urandom_range(0, 7)));
      else if (r < 94) send_key(8'h1B);
      else             send_key(8'($urandom_range(32, 126)));
    end

    // Asynchronous reset during an emit cycle aborts the write.
    send_printables(3);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_data  = 8'h51;
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    check("pre_rst_we", 32'(bus.we), 32'(1));
    #2 reset = 1'b1;
    #1;
    check("arst_we", 32'(bus.we), 32'(0));
    check("arst_cursor", 32'(bus.cursor), 32'(0));
    check("arst_d", 32'(bus.d), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    cur   = 0;
    #1;
    check("arst_ready", 32'(bus.key_ready), 32'(1));

`ifdef TEXT_CURSOR_WRITER_CLEAR_EN
    // Asynchronous reset at sweep address 20.
    send_printables(9);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_data  = 8'h1B;
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    model_key(8'h1B, wr, waddr, wdata, clr);
    for (int i = 0; i < 20; i++) begin
      model_ram[i] = 8'h20;
      @(posedge clk); #1;
    end
    check("clr_at20", 32'(bus.write_address), 32'(20));
    #2 reset = 1'b1;
    #1;
    check("clr_rst_we", 32'(bus.we), 32'(0));
    check("clr_rst_cursor", 32'(bus.cursor), 32'(0));
    check("clr_rst_busy", 32'(bus.busy), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    cur   = 0;
    #1;
    check("clr_rst_ready", 32'(bus.key_ready), 32'(1));
`endif

    // Post-reset traffic still behaves.
    send_printables(2);
    send_key(8'h08);

    // RAM contents produced by the write port.
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) check("ram", 32'(shadow[i]), 32'(model_ram[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
